dda_sched: RTL and testbench
============================

DDA_SCHED -- requirements
Module: dda_sched

Interface
REQ-001 SHALL have parameter NAXIS, default 3; number of DDA channels driven.
REQ-002 SHALL have parameter DEPTH, default 4; command FIFO entries per axis (power of 2).
REQ-003 SHALL have parameter PERIOD, default 50000; control period in clk cycles (2.5 ms at 20 MHz).
REQ-004 SHALL have port clk, input, 1; single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1; level; 1 means run the scheduler.
REQ-007 SHALL have port host_we, input, 1; one-cycle host write strobe.
REQ-008 SHALL have port host_addr, input, 2; target axis index.
REQ-009 SHALL have port host_data, input, 16; DDA command: bit15 = dir, bits11:0 = step count.
REQ-010 SHALL have port clr_err, input, 1; clears the sticky error flags.
REQ-011 SHALL have port dda_busy, input, NAXIS; busy outputs of the DDA channels.
REQ-012 SHALL have port dda_n, output, 16*NAXIS; command to each DDA; axis i occupies bits [16i+15:16i].
REQ-013 SHALL have port dda_wr, output, NAXIS; one-cycle load strobe to each DDA.
REQ-014 SHALL have port fifo_full, output, NAXIS; per-axis FIFO full.
REQ-015 SHALL have port tick, output, 1; one-cycle pulse at each period boundary.
REQ-016 SHALL have port underrun, output, 1; sticky error flag.
REQ-017 SHALL have port overrun, output, 1; sticky error flag.
REQ-018 SHALL have port state_o, output, 2; current FSM state.

Function
REQ-019 SHALL handle host_we as follows:
 - host_addr < NAXIS and FIFO not full: push host_data into that axis FIFO.
 - FIFO full: drop the write; no flag.
 - host_addr >= NAXIS: ignore the write.
REQ-020 SHALL, when a push and a pop hit the same FIFO in the same cycle, perform both; the count is unchanged.
REQ-021 SHALL implement states IDLE=0, FILL=1, LOAD=2, RUN=3.
REQ-022 SHALL behave in IDLE as follows: timer held at 0, FIFOs flushed, no strobes; go to FILL when enable=1.
REQ-023 SHALL behave in FILL as follows: wait until every FIFO is non-empty, then go to LOAD with timer=0.
REQ-024 SHALL behave in LOAD (exactly one cycle) as follows:
 - pop every FIFO;
 - dda_n = the popped words, registered and held until the next load;
 - dda_wr = all ones for this cycle only;
 - then go to RUN.
REQ-025 SHALL run the timer in LOAD and RUN, counting 0..PERIOD-1 and wrapping to 0.
REQ-026 SHALL assert tick for the cycle in which the timer equals PERIOD-1.
REQ-027 SHALL take these actions at tick in RUN:
 - any dda_busy bit =1: set overrun.
 - every FIFO non-empty: go to LOAD.
 - otherwise: set underrun; drive dda_n = 0 with dda_wr all ones for one cycle (stop all axes); go to FILL.
REQ-028 SHALL make the spacing between consecutive LOAD strobes in continuous running exactly PERIOD cycles.
REQ-029 SHALL, when enable=0 in any state, go to IDLE next cycle:
 - drive dda_n = 0 with one dda_wr strobe if leaving LOAD or RUN;
 - flush the FIFOs.
REQ-030 SHALL clear underrun and overrun on clr_err=1; if set and clear occur in the same cycle, set wins.
REQ-031 SHALL pass the 16-bit command unmodified; bits 14:12 are reserved and passed through.

Reset
REQ-032 SHALL, on rst_n=0, immediately:
 - force state to IDLE;
 - force timer, FIFO pointers and FIFO counts to 0;
 - force dda_n=0, dda_wr=0, tick=0, underrun=0, overrun=0.
 FIFO storage contents are don't-care.
REQ-033 SHALL, when reset is asserted mid-period, issue no stop strobe; the DDAs finish their own period.

Structure
REQ-034 SHALL place the state encoding, the command field positions (DIR_BIT=15, N_MSB=11) and the default PERIOD in a shared package, dda_pkg.
REQ-035 SHALL implement the per-axis FIFO as one sub-module, cmd_fifo, with parameters DEPTH and width 16, instantiated NAXIS times.

Verification (PERIOD=100 in bench)
REQ-036 SHALL verify normal load:
 - write 0x0005, 0x8003, 0x0000 to axes 0..2; enable=1.
 - Required: one dda_wr=3'b111 with dda_n={0x0000,0x8003,0x0005}, then state RUN.
REQ-037 SHALL verify period spacing:
 - keep FIFOs fed.
 - Required: dda_wr strobes exactly 100 cycles apart; tick one cycle before each strobe.
REQ-038 SHALL verify underrun:
 - load one command per axis only.
 - Required: at the next tick, dda_wr=3'b111 with dda_n=0, underrun=1, state FILL.
REQ-039 SHALL verify overrun:
 - hold dda_busy[1]=1 across a tick.
 - Required: overrun=1; clr_err clears it.
REQ-040 SHALL verify FIFO full:
 - 5 writes to axis 2 with DEPTH=4.
 - Required: fifo_full[2]=1; the 5th write is lost; the 4 stored words are popped in order.
REQ-041 SHALL verify reset mid-run:
 - rst_n=0 at timer=50.
 - Required: all outputs 0 within the same cycle; state IDLE; no strobe after release until enable and refill.

Source files
------------

// File: rtl/dda_pkg.sv
// Shared definitions for the DDA command scheduler: state encoding,
// command field layout and the default control period.
package dda_pkg;

    localparam int unsigned CMD_W      = 16;
    localparam int unsigned DIR_BIT    = 15;
    localparam int unsigned N_MSB      = 11;
    localparam int unsigned DEF_PERIOD = 50000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    // Field view of one DDA command word; bits 14:12 are reserved pass-through.
    typedef struct packed {
        logic                dir;
        logic [2:0]          rsvd;
        logic [N_MSB:0]      n;
    } dda_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Per-axis command FIFO with show-ahead read port, flush, and
// registered full/empty flags.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata_c,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_d;
    logic          push_ok;
    logic          pop_ok;

    // A write into a full FIFO is dropped even if a pop happens that cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata_c = mem[rd_ptr];

    always_comb begin : count_next
        count_d = count;
        if (flush) begin
            count_d = '0;
        end else if (push_ok && !pop_ok) begin
            count_d = count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin : storage
        if (push_ok && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/dda_sched.sv
// Periodic scheduler feeding NAXIS DDA channels from per-axis command
// FIFOs: loads all axes together once per control period.
module dda_sched
    import dda_pkg::*;
#(
    parameter int unsigned NAXIS  = 3,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PERIOD = DEF_PERIOD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   host_we,
    input  logic [1:0]             host_addr,
    input  logic [15:0]            host_data,
    input  logic                   clr_err,
    input  logic [NAXIS-1:0]       dda_busy,
    output logic [16*NAXIS-1:0]    dda_n,
    output logic [NAXIS-1:0]       dda_wr,
    output logic [NAXIS-1:0]       fifo_full,
    output logic                   tick,
    output logic                   underrun,
    output logic                   overrun,
    output logic [1:0]             state_o
);

    localparam int unsigned TW = $clog2(PERIOD + 1);

    logic [1:0]             state;
    logic [1:0]             state_d;
    logic [TW-1:0]          timer;
    logic [TW-1:0]          timer_d;
    logic [TW-1:0]          timer_inc;
    logic [16*NAXIS-1:0]    dda_n_d;
    logic [NAXIS-1:0]       dda_wr_d;
    logic                   tick_d;
    logic                   und_set;
    logic                   ovr_set;

    logic [CMD_W*NAXIS-1:0] heads;
    logic [NAXIS-1:0]       empty;
    logic [NAXIS-1:0]       push;
    logic                   flush_c;
    logic                   pop_c;
    logic                   all_ready;
    logic                   period_end;

    assign flush_c    = !enable || (state == ST_IDLE);
    assign pop_c      = (state == ST_LOAD);
    assign all_ready  = ~|empty;
    assign period_end = (timer == TW'(PERIOD - 1));
    assign timer_inc  = period_end ? '0 : timer + TW'(1);
    assign state_o    = state;

    // Axis FIFOs; addresses at or above NAXIS match no axis and are ignored.
    for (genvar i = 0; i < NAXIS; i++) begin : g_axis
        assign push[i] = host_we && (host_addr == 2'(i));

        cmd_fifo #(
            .DEPTH (DEPTH),
            .W     (CMD_W)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush_c),
            .push    (push[i]),
            .pop     (pop_c),
            .wdata   (host_data),
            .rdata_c (heads[i*CMD_W +: CMD_W]),
            .full    (fifo_full[i]),
            .empty   (empty[i])
        );
    end

    // Next-state, timer and strobe decode.
    always_comb begin : next_state
        state_d  = state;
        timer_d  = timer;
        dda_n_d  = dda_n;
        dda_wr_d = '0;
        und_set  = 1'b0;
        ovr_set  = 1'b0;

        case (state)
            ST_IDLE: begin
                timer_d = '0;
                if (enable) state_d = ST_FILL;
            end
            ST_FILL: begin
                timer_d = '0;
                if (all_ready) begin
                    state_d  = ST_LOAD;
                    dda_n_d  = heads;
                    dda_wr_d = '1;
                end
            end
            ST_LOAD: begin
                timer_d = timer_inc;
                state_d = ST_RUN;
            end
            default: begin
                timer_d = timer_inc;
                if (period_end) begin
                    ovr_set = |dda_busy;
                    if (all_ready) begin
                        state_d  = ST_LOAD;
                        dda_n_d  = heads;
                        dda_wr_d = '1;
                    end else begin
                        und_set  = 1'b1;
                        state_d  = ST_FILL;
                        dda_n_d  = '0;
                        dda_wr_d = '1;
                    end
                end
            end
        endcase

        // Disabling stops any moving axis with a zero command.
        if (!enable) begin
            state_d = ST_IDLE;
            timer_d = '0;
            if (state == ST_LOAD || state == ST_RUN) begin
                dda_n_d  = '0;
                dda_wr_d = '1;
            end else begin
                dda_n_d  = dda_n;
                dda_wr_d = '0;
            end
        end

        tick_d = ((state_d == ST_LOAD) || (state_d == ST_RUN)) &&
                 (timer_d == TW'(PERIOD - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            dda_n    <= '0;
            dda_wr   <= '0;
            tick     <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            dda_n    <= dda_n_d;
            dda_wr   <= dda_wr_d;
            tick     <= tick_d;
            underrun <= und_set | (underrun & ~clr_err);
            overrun  <= ovr_set | (overrun & ~clr_err);
        end
    end

endmodule

// File: tb/tb_dda_sched.sv
// Self-checking bench for dda_sched (PERIOD=100) with a queue-style
// model of the per-axis command FIFOs.
module tb_dda_sched;

    localparam int unsigned NAX = 3;
    localparam int unsigned DEP = 4;
    localparam int unsigned PER = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        host_we = 1'b0;
    logic [1:0]  host_addr = '0;
    logic [15:0] host_data = '0;
    logic        clr_err = 1'b0;
    logic [2:0]  dda_busy = '0;
    logic [47:0] dda_n;
    logic [2:0]  dda_wr;
    logic [2:0]  fifo_full;
    logic        tick;
    logic        underrun;
    logic        overrun;
    logic [1:0]  state_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model: ring per axis, capacity DEP, pops take the oldest word.
    logic [15:0] mmem [3][16];
    int          mhead [3];
    int          mcnt [3];

    dda_sched #(
        .NAXIS  (NAX),
        .DEPTH  (DEP),
        .PERIOD (PER)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_data (host_data),
        .clr_err   (clr_err),
        .dda_busy  (dda_busy),
        .dda_n     (dda_n),
        .dda_wr    (dda_wr),
        .fifo_full (fifo_full),
        .tick      (tick),
        .underrun  (underrun),
        .overrun   (overrun),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            mhead[i] = 0;
            mcnt[i]  = 0;
        end
    endfunction

    function automatic void model_push(input int a, input logic [15:0] d);
        if (a < int'(NAX) && mcnt[a] < int'(DEP)) begin
            mmem[a][(mhead[a] + mcnt[a]) % 16] = d;
            mcnt[a]++;
        end
    endfunction

    function automatic logic [47:0] model_front();
        logic [47:0] r;
        for (int i = 0; i < 3; i++) r[16*i +: 16] = mmem[i][mhead[i]];
        return r;
    endfunction

    function automatic void model_pop();
        for (int i = 0; i < 3; i++) begin
            if (mcnt[i] > 0) begin
                mhead[i] = (mhead[i] + 1) % 16;
                mcnt[i]--;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input logic [15:0] d);
        host_addr = 2'(a);
        host_data = d;
        host_we   = 1'b1;
        model_push(a, d);
        step();
        host_we   = 1'b0;
    endtask

    task automatic write_all_random();
        for (int a = 0; a < 3; a++) host_write(a, 16'($urandom));
    endtask

    // Steps until a load strobe appears; reports steps taken and tick one cycle earlier.
    task automatic wait_strobe(input int max, output int n, output logic pt, output logic ok);
        logic prev;
        n    = 0;
        ok   = 1'b0;
        prev = 1'b0;
        pt   = 1'b0;
        while (n < max && !ok) begin
            prev = tick;
            step();
            n++;
            if (dda_wr != 3'b000) begin
                ok = 1'b1;
                pt = prev;
            end
        end
    endtask

    task automatic restart();
        enable   = 1'b0;
        dda_busy = '0;
        step();
        step();
        model_clear();
        enable = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        #12;
        total_cnt++; if (state_o !== 2'd0) $display("FAIL rst_state: got %0d want 0", state_o); else pass_cnt++;
        total_cnt++; if (dda_wr !== 3'b000) $display("FAIL rst_wr: got %b want 000", dda_wr); else pass_cnt++;
        total_cnt++; if (dda_n !== 48'h0) $display("FAIL rst_n: got %h want 0", dda_n); else pass_cnt++;
        total_cnt++; if (tick !== 1'b0) $display("FAIL rst_tick: got %b want 0", tick); else pass_cnt++;
        total_cnt++; if ({underrun, overrun} !== 2'b00) $display("FAIL rst_err: got %b want 00", {underrun, overrun}); else pass_cnt++;
        total_cnt++; if (fifo_full !== 3'b000) $display("FAIL rst_full: got %b want 000", fifo_full); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        step();
        total_cnt++; if (state_o !== 2'd0) $display("FAIL idle_hold: got %0d want 0", state_o); else pass_cnt++;
    endtask

    task automatic test_normal_load();
        int n; logic pt, ok;
        restart();
        total_cnt++; if (state_o !== 2'd1) $display("FAIL nl_fill: got %0d want 1", state_o); else pass_cnt++;
        host_write(0, 16'h0005);
        host_write(1, 16'h8003);
        host_write(2, 16'h0000);
        wait_strobe(10, n, pt, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL nl_timeout: got no strobe want strobe"); else pass_cnt++;
        total_cnt++; if (dda_wr !== 3'b111) $display("FAIL nl_wr: got %b want 111", dda_wr); else pass_cnt++;
        total_cnt++; if (dda_n !== 48'h0000_8003_0005) $display("FAIL nl_data: got %h want 000080030005", dda_n); else pass_cnt++;
        model_pop();
        step();
        total_cnt++; if (state_o !== 2'd3) $display("FAIL nl_run: got %0d want 3", state_o); else pass_cnt++;
        total_cnt++; if (dda_wr !== 3'b000) $display("FAIL nl_one_shot: got %b want 000", dda_wr); else pass_cnt++;
        total_cnt++; if (dda_n !== 48'h0000_8003_0005) $display("FAIL nl_hold: got %h want 000080030005", dda_n); else pass_cnt++;
        enable = 1'b0;
        step();
        total_cnt++; if (dda_wr !== 3'b111 || dda_n !== 48'h0) $display("FAIL nl_stop: got wr=%b n=%h want wr=111 n=0", dda_wr, dda_n); else pass_cnt++;
        step();
        total_cnt++; if (state_o !== 2'd0 || dda_wr !== 3'b000) $display("FAIL nl_idle: got st=%0d wr=%b want st=0 wr=000", state_o, dda_wr); else pass_cnt++;
    endtask

    task automatic test_period_spacing();
        int n; logic pt, ok;
        logic [47:0] exp;
        restart();
        write_all_random();
        wait_strobe(10, n, pt, ok);
        exp = model_front();
        total_cnt++; if (!ok || dda_n !== exp) $display("FAIL ps_first: got ok=%b n=%h want ok=1 n=%h", ok, dda_n, exp); else pass_cnt++;
        model_pop();
        for (int k = 0; k < 5; k++) begin
            write_all_random();
            wait_strobe(150, n, pt, ok);
            exp = model_front();
            total_cnt++; if (!ok || n + 3 != int'(PER)) $display("FAIL ps_spacing%0d: got %0d cycles want %0d", k, n + 3, PER); else pass_cnt++;
            total_cnt++; if (pt !== 1'b1) $display("FAIL ps_tick%0d: got %b want 1", k, pt); else pass_cnt++;
            total_cnt++; if (dda_wr !== 3'b111 || dda_n !== exp) $display("FAIL ps_data%0d: got wr=%b n=%h want wr=111 n=%h", k, dda_wr, dda_n, exp); else pass_cnt++;
            model_pop();
        end
    endtask

    task automatic test_underrun();
        int n; logic pt, ok;
        restart();
        write_all_random();
        wait_strobe(10, n, pt, ok);
        total_cnt++; if (!ok || dda_n !== model_front()) $display("FAIL ur_load: got ok=%b n=%h want ok=1 n=%h", ok, dda_n, model_front()); else pass_cnt++;
        model_pop();
        wait_strobe(150, n, pt, ok);
        total_cnt++; if (!ok || n != int'(PER) || pt !== 1'b1) $display("FAIL ur_timing: got ok=%b cycles=%0d tick=%b want ok=1 cycles=%0d tick=1", ok, n, pt, PER); else pass_cnt++;
        total_cnt++; if (dda_wr !== 3'b111 || dda_n !== 48'h0) $display("FAIL ur_stop: got wr=%b n=%h want wr=111 n=0", dda_wr, dda_n); else pass_cnt++;
        total_cnt++; if (underrun !== 1'b1 || overrun !== 1'b0) $display("FAIL ur_flags: got ur=%b ov=%b want ur=1 ov=0", underrun, overrun); else pass_cnt++;
        total_cnt++; if (state_o !== 2'd1) $display("FAIL ur_state: got %0d want 1", state_o); else pass_cnt++;
        step();
        total_cnt++; if (underrun !== 1'b1) $display("FAIL ur_sticky: got %b want 1", underrun); else pass_cnt++;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        total_cnt++; if (underrun !== 1'b0) $display("FAIL ur_clear: got %b want 0", underrun); else pass_cnt++;
    endtask

    task automatic test_overrun();
        int n; logic pt, ok;
        restart();
        write_all_random();
        wait_strobe(10, n, pt, ok);
        model_pop();
        total_cnt++; if (!ok || overrun !== 1'b0) $display("FAIL ov_pre: got ok=%b ov=%b want ok=1 ov=0", ok, overrun); else pass_cnt++;
        dda_busy = 3'b010;
        clr_err  = 1'b1;
        wait_strobe(150, n, pt, ok);
        total_cnt++; if (!ok || overrun !== 1'b1) $display("FAIL ov_set_wins: got ok=%b ov=%b want ok=1 ov=1", ok, overrun); else pass_cnt++;
        total_cnt++; if (underrun !== 1'b1) $display("FAIL ov_ur_set_wins: got %b want 1", underrun); else pass_cnt++;
        step();
        total_cnt++; if (overrun !== 1'b0 || underrun !== 1'b0) $display("FAIL ov_clear: got ov=%b ur=%b want 0 0", overrun, underrun); else pass_cnt++;
        clr_err  = 1'b0;
        dda_busy = 3'b000;
    endtask

    task automatic test_fifo_full();
        int n; logic pt, ok;
        logic [47:0] exp;
        restart();
        for (int j = 0; j < 4; j++) host_write(2, 16'($urandom));
        total_cnt++; if (fifo_full !== 3'b100) $display("FAIL ff_full: got %b want 100", fifo_full); else pass_cnt++;
        host_write(2, 16'($urandom));
        host_write(3, 16'($urandom));
        total_cnt++; if (fifo_full !== 3'b100 || state_o !== 2'd1) $display("FAIL ff_hold: got full=%b st=%0d want full=100 st=1", fifo_full, state_o); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            host_write(0, 16'($urandom));
            host_write(1, 16'($urandom));
            wait_strobe(150, n, pt, ok);
            exp = model_front();
            total_cnt++; if (!ok || dda_n !== exp) $display("FAIL ff_order%0d: got ok=%b n=%h want ok=1 n=%h", k, ok, dda_n, exp); else pass_cnt++;
            model_pop();
        end
        step();
        total_cnt++; if (fifo_full !== 3'b000) $display("FAIL ff_drained: got %b want 000", fifo_full); else pass_cnt++;
        wait_strobe(150, n, pt, ok);
        total_cnt++; if (!ok || dda_n !== 48'h0 || underrun !== 1'b1) $display("FAIL ff_lost5th: got ok=%b n=%h ur=%b want ok=1 n=0 ur=1", ok, dda_n, underrun); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int n; int strobes; logic pt, ok;
        logic [47:0] exp;
        restart();
        for (int a = 0; a < 3; a++) host_write(a, 16'($urandom) | 16'h0001);
        wait_strobe(10, n, pt, ok);
        model_pop();
        dda_busy = 3'b001;
        for (int a = 0; a < 3; a++) host_write(a, 16'($urandom) | 16'h0001);
        wait_strobe(150, n, pt, ok);
        exp = model_front();
        model_pop();
        dda_busy = 3'b000;
        total_cnt++; if (!ok || dda_n !== exp || overrun !== 1'b1) $display("FAIL rm_pre: got ok=%b n=%h ov=%b want ok=1 n=%h ov=1", ok, dda_n, overrun, exp); else pass_cnt++;
        for (int c = 0; c < 50; c++) step();
        rst_n = 1'b0;
        #1;
        total_cnt++; if (dda_n !== 48'h0 || dda_wr !== 3'b000) $display("FAIL rm_dda: got n=%h wr=%b want 0 000", dda_n, dda_wr); else pass_cnt++;
        total_cnt++; if ({tick, underrun, overrun} !== 3'b000) $display("FAIL rm_flags: got %b want 000", {tick, underrun, overrun}); else pass_cnt++;
        total_cnt++; if (state_o !== 2'd0) $display("FAIL rm_state: got %0d want 0", state_o); else pass_cnt++;
        step();
        rst_n = 1'b1;
        model_clear();
        strobes = 0;
        for (int c = 0; c < 150; c++) begin
            step();
            if (dda_wr != 3'b000) strobes++;
        end
        total_cnt++; if (strobes != 0 || state_o !== 2'd1) $display("FAIL rm_quiet: got strobes=%0d st=%0d want 0 1", strobes, state_o); else pass_cnt++;
        write_all_random();
        wait_strobe(10, n, pt, ok);
        exp = model_front();
        total_cnt++; if (!ok || dda_n !== exp) $display("FAIL rm_refill: got ok=%b n=%h want ok=1 n=%h", ok, dda_n, exp); else pass_cnt++;
        model_pop();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_normal_load();
        test_period_spacing();
        test_underrun();
        test_overrun();
        test_fifo_full();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
